// File: rtl/tick_sched_if.sv
// Configuration-request and expiry-event handshakes for tick_sched.
// The slave side is the scheduler, the master side is its host.
interface tick_sched_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = $clog2(NCH);

  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_ch;
  logic [1:0]       req_tb;
  logic [CNT_W-1:0] req_cnt;
  logic             req_periodic;
  logic             evt_valid;
  logic             evt_ready;
  logic [CH_W-1:0]  evt_ch;

  modport master (
    output req_valid, req_ch, req_tb, req_cnt, req_periodic, evt_ready,
    input  req_ready, evt_valid, evt_ch
  );

  modport slave (
    input  req_valid, req_ch, req_tb, req_cnt, req_periodic, evt_ready,
    output req_ready, evt_valid, evt_ch
  );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: per-channel down-counters on one of
// three timebases, expiries queued as round-robin arbitrated events.
module tick_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_32khz,
  input  logic           ce_8hz,
  input  logic           ce_1hz,
  tick_sched_if.slave    bus,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] ovf
);
  localparam int CH_W = $clog2(NCH);

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] rld_q [NCH];
  logic [1:0]       tb_q  [NCH];
  logic [NCH-1:0]   per_q;
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   active_q;
  logic [NCH-1:0]   ovf_q;
  logic [CH_W-1:0]  rr_q;
  logic [CH_W-1:0]  hold_ch_q;
  logic             hold_q;
  logic             ready_q;

  logic [3:0]       ce_vec;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   exp_v;
  logic [NCH-1:0]   clr_v;
  logic [CH_W-1:0]  arb_ch;
  logic [CH_W-1:0]  sel_ch;
  logic             found;
  int               idx;
  logic             acc;
  logic             hs;
  logic             go;

  assign ce_vec = {ce_1hz, ce_8hz, ce_32khz, 1'b0};

  assign bus.req_ready = ready_q & ~rst;
  assign bus.evt_valid = |pend_q;
  assign bus.evt_ch    = sel_ch;
  assign active        = active_q;
  assign ovf           = ovf_q;

  assign acc = bus.req_valid & bus.req_ready;
  assign hs  = bus.evt_valid & bus.evt_ready;
  assign go  = (bus.req_tb != 2'b00) && (bus.req_cnt != '0);

  always_comb begin
    arb_ch = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pend_q[idx]) begin
        found  = 1'b1;
        arb_ch = CH_W'(idx);
      end
    end
  end

  // A presented event is frozen until taken, even if a new one
  // lands earlier in the round-robin order.
  assign sel_ch = hold_q ? hold_ch_q : arb_ch;

  always_comb begin
    tick  = '0;
    hit   = '0;
    exp_v = '0;
    clr_v = '0;
    for (int i = 0; i < NCH; i++) begin
      tick[i]  = active_q[i] & ce_vec[tb_q[i]];
      hit[i]   = acc && (bus.req_ch == CH_W'(i));
      exp_v[i] = tick[i] && !hit[i] && (cnt_q[i] == CNT_W'(1));
      clr_v[i] = hs && (sel_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        rld_q[i] <= '0;
        tb_q[i]  <= '0;
      end
      per_q     <= '0;
      pend_q    <= '0;
      active_q  <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          cnt_q[i]    <= go ? bus.req_cnt : '0;
          rld_q[i]    <= bus.req_cnt;
          tb_q[i]     <= bus.req_tb;
          per_q[i]    <= bus.req_periodic;
          active_q[i] <= go;
          ovf_q[i]    <= 1'b0;
        end else if (exp_v[i]) begin
          if (per_q[i]) begin
            cnt_q[i] <= rld_q[i];
          end else begin
            cnt_q[i]    <= '0;
            active_q[i] <= 1'b0;
          end
          if (pend_q[i] && !clr_v[i]) ovf_q[i] <= 1'b1;
        end else if (tick[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      pend_q <= exp_v | (pend_q & ~clr_v);
      if (hs) begin
        rr_q   <= (sel_ch == CH_W'(NCH - 1)) ? '0 : sel_ch + 1'b1;
        hold_q <= 1'b0;
      end else if (bus.evt_valid) begin
        hold_q    <= 1'b1;
        hold_ch_q <= sel_ch;
      end
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: expected event channels are queued
// by the stimulus and popped by a monitor on each event handshake.
module tb_tick_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       ce_32khz;
  logic       ce_8hz;
  logic       ce_1hz;
  logic [3:0] active;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_e;

  tick_sched_if #(.NCH(4), .CNT_W(8)) bus ();

  tick_sched #(.NCH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce_32khz (ce_32khz),
    .ce_8hz   (ce_8hz),
    .ce_1hz   (ce_1hz),
    .bus      (bus),
    .active   (active),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got ch %0d, required none", bus.evt_ch);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.evt_ch !== mon_e[1:0]) begin
          errors++;
          $display("FAIL evt_ch_order: got %0d, required %0d", bus.evt_ch, mon_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input logic [2:0] ce, input int n);
    repeat (n) begin
      {ce_1hz, ce_8hz, ce_32khz} = ce;
      step(1);
      {ce_1hz, ce_8hz, ce_32khz} = 3'b000;
    end
  endtask

  task automatic cfg(input int ch, input logic [1:0] tb, input int cnt,
                     input logic per, input logic [2:0] ce);
    bus.req_valid    = 1'b1;
    bus.req_ch       = 2'(ch);
    bus.req_tb       = tb;
    bus.req_cnt      = 8'(cnt);
    bus.req_periodic = per;
    {ce_1hz, ce_8hz, ce_32khz} = ce;
    step(1);
    bus.req_valid = 1'b0;
    {ce_1hz, ce_8hz, ce_32khz} = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    chk("rst_ready_in_reset", 32'(bus.req_ready), 0);
    step(1);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 32'(bus.req_ready), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 0);
    step(1);
    chk("rst_ready_back", 32'(bus.req_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    {ce_1hz, ce_8hz, ce_32khz} = 3'b000;
    bus.req_valid    = 1'b0;
    bus.req_ch       = '0;
    bus.req_tb       = '0;
    bus.req_cnt      = '0;
    bus.req_periodic = 1'b0;
    bus.evt_ready    = 1'b1;
    do_reset();

    // one-shot on 32 kHz
    cfg(0, 2'b01, 3, 1'b0, 3'b000);
    chk("os_active_load", 32'(active), 32'h1);
    ticks(3'b001, 2);
    chk("os_no_evt_early", 32'(bus.evt_valid), 0);
    exp_q.push_back(0);
    ticks(3'b001, 1);
    chk("os_evt_valid", 32'(bus.evt_valid), 1);
    chk("os_evt_ch", 32'(bus.evt_ch), 0);
    chk("os_active_clr", 32'(active), 0);
    step(1);
    chk("os_evt_taken", 32'(bus.evt_valid), 0);

    // periodic on 8 Hz
    cfg(1, 2'b10, 2, 1'b1, 3'b000);
    repeat (3) exp_q.push_back(1);
    ticks(3'b010, 6);
    step(2);
    chk("per_active", 32'(active), 32'h2);
    chk("per_ovf", 32'(ovf), 0);
    chk("per_drained", exp_q.size(), 0);
    cfg(1, 2'b00, 0, 1'b0, 3'b000);
    chk("per_stopped", 32'(active), 0);

    // simultaneous expiry, round-robin order
    do_reset();
    for (int c = 0; c < 4; c++) cfg(c, 2'b11, 1, 1'b0, 3'b000);
    chk("rr_active_all", 32'(active), 32'hF);
    for (int c = 0; c < 4; c++) exp_q.push_back(c);
    ticks(3'b100, 1);
    chk("rr_first_valid", 32'(bus.evt_valid), 1);
    chk("rr_first_ch", 32'(bus.evt_ch), 0);
    step(4);
    chk("rr_drained_4cyc", exp_q.size(), 0);
    chk("rr_idle", 32'(bus.evt_valid), 0);
    chk("rr_inactive", 32'(active), 0);
    cfg(2, 2'b11, 1, 1'b0, 3'b000);
    exp_q.push_back(2);
    ticks(3'b100, 1);
    chk("rr_wrap_ch", 32'(bus.evt_ch), 2);
    step(1);
    chk("rr_wrap_drained", exp_q.size(), 0);

    // overflow while pending
    bus.evt_ready = 1'b0;
    cfg(2, 2'b11, 1, 1'b1, 3'b000);
    ticks(3'b100, 1);
    chk("ovf_pend_valid", 32'(bus.evt_valid), 1);
    chk("ovf_none_yet", 32'(ovf), 0);
    ticks(3'b100, 1);
    chk("ovf_set", 32'(ovf), 32'h4);
    chk("ovf_evt_ch", 32'(bus.evt_ch), 2);
    cfg(2, 2'b11, 5, 1'b1, 3'b000);
    chk("ovf_cleared", 32'(ovf), 0);
    chk("ovf_still_pend", 32'(bus.evt_valid), 1);
    chk("ovf_reload_active", 32'(active), 32'h4);
    exp_q.push_back(2);
    bus.evt_ready = 1'b1;
    step(2);
    chk("ovf_single_evt", 32'(bus.evt_valid), 0);
    chk("ovf_drained", exp_q.size(), 0);
    cfg(2, 2'b00, 0, 1'b0, 3'b000);

    // presented channel held while stalled
    bus.evt_ready = 1'b0;
    cfg(0, 2'b01, 1, 1'b0, 3'b000);
    cfg(3, 2'b10, 1, 1'b0, 3'b000);
    ticks(3'b001, 1);
    chk("hold_first", 32'(bus.evt_ch), 0);
    ticks(3'b010, 1);
    chk("hold_valid", 32'(bus.evt_valid), 1);
    chk("hold_stable", 32'(bus.evt_ch), 0);
    exp_q.push_back(0);
    exp_q.push_back(3);
    bus.evt_ready = 1'b1;
    step(3);
    chk("hold_drained", exp_q.size(), 0);
    chk("hold_idle", 32'(bus.evt_valid), 0);

    // request wins over a coincident final tick
    cfg(3, 2'b01, 1, 1'b0, 3'b000);
    cfg(3, 2'b01, 2, 1'b0, 3'b001);
    chk("coin_no_evt", 32'(bus.evt_valid), 0);
    chk("coin_active", 32'(active), 32'h8);
    ticks(3'b001, 1);
    chk("coin_cnt2_left1", 32'(bus.evt_valid), 0);
    exp_q.push_back(3);
    ticks(3'b001, 1);
    chk("coin_expire_ch", 32'(bus.evt_ch), 3);
    step(1);
    chk("coin_drained", exp_q.size(), 0);
    chk("coin_oneshot_done", 32'(active), 0);
    cfg(3, 2'b01, 1, 1'b0, 3'b000);
    cfg(3, 2'b01, 0, 1'b0, 3'b001);
    chk("coin_zero_inactive", 32'(active), 0);
    chk("coin_zero_no_evt", 32'(bus.evt_valid), 0);

    // reset aborts running and pending channels
    bus.evt_ready = 1'b0;
    cfg(0, 2'b01, 5, 1'b1, 3'b000);
    cfg(1, 2'b01, 1, 1'b1, 3'b000);
    ticks(3'b001, 2);
    chk("pre_rst_ovf", 32'(ovf), 32'h2);
    chk("pre_rst_pend", 32'(bus.evt_valid), 1);
    chk("pre_rst_active", 32'(active), 32'h3);
    do_reset();
    bus.evt_ready = 1'b1;
    ticks(3'b001, 6);
    chk("post_rst_no_evt", 32'(bus.evt_valid), 0);
    step(2);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
